// File: rtl/mode7_param_fetch_if.sv
// Bank read port between the Mode7 parameter fetcher and the parameter bank.
//   rd_index : bank read address, driven by the fetcher (master)
//   rd_data  : sign-magnitude bank word, returned by the bank (slave)
interface mode7_param_fetch_if #(
  parameter int W = 24
);
  logic [3:0]   rd_index;
  logic [W-1:0] rd_data;

  modport master (output rd_index, input rd_data);
  modport slave  (input rd_index, output rd_data);
endinterface

// File: rtl/mode7_param_fetch.sv
// Mode7 parameter fetcher: on each frame_start it walks the bank read port
// over indices 0..NUM_PARAMS-1. It converts every sign-magnitude word to
// two's complement in a staging set, then commits the whole set to the
// renderer in a single edge so a frame never mixes old and new values.
// Ports:
//   clk, reset     : clock, asynchronous active-high reset
//   frame_start    : 1-cycle start-of-vblank pulse
//   bank           : bank read port (rd_index out, rd_data in)
//   params_tc      : committed two's-complement set, entry k at [W*k +: W]
//   params_valid   : a set has been committed since reset
//   params_update  : 1-cycle pulse in the cycle after a commit
//   busy           : fetch or commit in progress
//   frame_miss     : 1-cycle pulse, frame_start ignored while busy
module mode7_param_fetch #(
  parameter int NUM_PARAMS = 9,
  parameter int W          = 24,
  parameter int RD_LAT     = 1
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    frame_start,
  mode7_param_fetch_if.master     bank,
  output logic [NUM_PARAMS*W-1:0] params_tc,
  output logic                    params_valid,
  output logic                    params_update,
  output logic                    busy,
  output logic                    frame_miss
);

  localparam int CW = 5;

  typedef enum logic [1:0] {IDLE, FETCH, COMMIT} state_t;

  state_t              state, state_nxt;
  logic [CW-1:0]       cnt;        // edges elapsed since the accepting edge, minus one
  logic [CW-1:0]       cap_idx;
  logic                cap_en;
  logic                cap_last;
  logic signed [W-1:0] staging [NUM_PARAMS];

  function automatic logic signed [W-1:0] to_tc(input logic [W-1:0] v);
    logic signed [W-1:0] m;
    m = {1'b0, v[W-2:0]};
    // Negating a zero magnitude yields zero, so negative zero needs no special case.
    return v[W-1] ? -m : m;
  endfunction

  // The word arriving now belongs to the index issued RD_LAT edges ago.
  assign cap_en   = (state == FETCH) && ((cnt + CW'(1)) >= CW'(RD_LAT));
  assign cap_idx  = cnt + CW'(1) - CW'(RD_LAT);
  assign cap_last = cap_en && (cap_idx == CW'(NUM_PARAMS - 1));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (frame_start) state_nxt = FETCH;
      FETCH:   if (cap_last)    state_nxt = COMMIT;
      COMMIT:                   state_nxt = IDLE;
      default:                  state_nxt = IDLE;
    endcase
  end

  always_comb begin
    busy = (state != IDLE);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt           <= '0;
      bank.rd_index <= '0;
      params_tc     <= '0;
      params_valid  <= 1'b0;
      params_update <= 1'b0;
      frame_miss    <= 1'b0;
      for (int k = 0; k < NUM_PARAMS; k++) staging[k] <= '0;
    end else begin
      params_update <= (state == COMMIT);
      frame_miss    <= frame_start && (state != IDLE);
      case (state)
        IDLE: begin
          cnt           <= '0;
          bank.rd_index <= '0;
        end
        // fetch stage: issue addresses and capture converted words into staging
        FETCH: begin
          cnt <= cnt + CW'(1);
          if (bank.rd_index != 4'(NUM_PARAMS - 1))
            bank.rd_index <= bank.rd_index + 4'd1;
          for (int k = 0; k < NUM_PARAMS; k++)
            if (cap_en && (cap_idx == CW'(k))) staging[k] <= to_tc(bank.rd_data);
        end
        // commit stage: publish the whole staged set at once
        COMMIT: begin
          for (int k = 0; k < NUM_PARAMS; k++) params_tc[W*k +: W] <= staging[k];
          params_valid  <= 1'b1;
          bank.rd_index <= '0;
        end
        default: begin
          cnt           <= '0;
          bank.rd_index <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mode7_param_fetch.sv
module tb_mode7_param_fetch;

  localparam int NP = 9;
  localparam int W  = 24;

  logic          clk;
  logic          reset;
  logic          frame_start;
  logic [NP*W-1:0] params_tc;
  logic          params_valid;
  logic          params_update;
  logic          busy;
  logic          frame_miss;

  logic [W-1:0]  bank [NP];

  int checks   = 0;
  int failures = 0;

  int upd_a  [32];
  int miss_a [32];
  int busy_a [32];
  int idx_a  [32];
  logic [W-1:0] tc0_a [32];

  typedef struct {
    logic [W-1:0] sm;
    logic [W-1:0] tc;
  } vec_t;

  vec_t tbl [NP];

  mode7_param_fetch_if #(.W(W)) bus ();

  // Bank model: the address is registered in the fetcher, data is available
  // in the cycle following the address edge.
  assign bus.rd_data = (bus.rd_index < 4'(NP)) ? bank[bus.rd_index] : 24'hDEAD00;

  mode7_param_fetch #(.NUM_PARAMS(NP), .W(W), .RD_LAT(1)) dut (
    .clk           (clk),
    .reset         (reset),
    .frame_start   (frame_start),
    .bank          (bus.master),
    .params_tc     (params_tc),
    .params_valid  (params_valid),
    .params_update (params_update),
    .busy          (busy),
    .frame_miss    (frame_miss)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  function automatic logic [W-1:0] entry(input int k);
    return params_tc[W*k +: W];
  endfunction

  // Reference: signed value = +/- magnitude, reduced to W bits.
  function automatic logic [W-1:0] ref_tc(input logic [W-1:0] v);
    logic signed [31:0] mag;
    logic signed [31:0] r;
    mag = 32'(v[W-2:0]);
    r   = v[W-1] ? (32'sd0 - mag) : mag;
    return r[W-1:0];
  endfunction

  // Pulse frame_start so the accepting edge is T, then record outputs in
  // cycles T+0..T+ncyc-1. Optionally raise frame_start during cycle inj and
  // rewrite bank[0] during cycle wr_cyc.
  task automatic run_frame(input int inj, input int wr_cyc, input logic [W-1:0] wr_val,
                           input int ncyc);
    @(negedge clk) frame_start = 1'b1;
    @(negedge clk) frame_start = 1'b0;
    for (int n = 0; n < ncyc; n++) begin
      upd_a[n]  = int'(params_update);
      miss_a[n] = int'(frame_miss);
      busy_a[n] = int'(busy);
      idx_a[n]  = int'(bus.rd_index);
      tc0_a[n]  = entry(0);
      frame_start = (n == inj);
      if (n == wr_cyc) bank[0] = wr_val;
      if (n < ncyc - 1) @(negedge clk);
    end
    frame_start = 1'b0;
    @(negedge clk);
  endtask

  function automatic int count_ones(input int a [32], input int ncyc);
    int c = 0;
    for (int n = 0; n < ncyc; n++) c += a[n];
    return c;
  endfunction

  initial begin
    int ok;
    reset       = 1'b1;
    frame_start = 1'b0;
    for (int k = 0; k < NP; k++) bank[k] = {1'b0, 15'(k + 1), 8'h00};

    tbl[0] = '{24'h000100, 24'h000100};
    tbl[1] = '{24'h800100, 24'hFFFF00};
    tbl[2] = '{24'h800000, 24'h000000};
    tbl[3] = '{24'h7FFFFF, 24'h7FFFFF};
    tbl[4] = '{24'hFFFFFF, 24'h800001};
    tbl[5] = '{24'h000001, 24'h000001};
    tbl[6] = '{24'h800001, 24'hFFFFFF};
    tbl[7] = '{24'h123456, 24'h123456};
    tbl[8] = '{24'h800180, 24'hFFFE80};

    repeat (2) @(negedge clk);
    chk("reset_params_tc", 64'(params_tc != '0), 64'd0);
    chk("reset_valid", 64'(params_valid), 64'd0);
    chk("reset_busy", 64'(busy), 64'd0);
    chk("reset_update", 64'(params_update), 64'd0);
    chk("reset_rd_index", 64'(bus.rd_index), 64'd0);
    reset = 1'b0;
    @(negedge clk);
    chk("idle_miss", 64'(frame_miss), 64'd0);

    // Basic frame: timing of busy, update and rd_index walk
    run_frame(-1, -1, '0, 13);
    ok = 1;
    for (int n = 0; n < 13; n++) if (busy_a[n] != (n <= 9 ? 1 : 0)) ok = 0;
    chk("t1_busy_window", 64'(ok), 64'd1);
    chk("t1_update_at_10", 64'(upd_a[10]), 64'd1);
    chk("t1_update_count", 64'(count_ones(upd_a, 13)), 64'd1);
    for (int k = 0; k < NP; k++) chk($sformatf("t1_entry%0d", k), 64'(entry(k)), 64'((k + 1) << 8));
    chk("t1_valid", 64'(params_valid), 64'd1);

    // Conversion vectors from the table
    for (int k = 0; k < NP; k++) bank[k] = tbl[k].sm;
    run_frame(-1, -1, '0, 12);
    for (int k = 0; k < NP; k++)
      chk($sformatf("tbl_entry%0d_sm%0h", k, tbl[k].sm), 64'(entry(k)), 64'(tbl[k].tc));

    // Bank rewrite during fetch must wait for the next frame
    run_frame(-1, 4, 24'h000500, 12);
    ok = 1;
    for (int n = 0; n < 12; n++) if (tc0_a[n] !== 24'h000100) ok = 0;
    chk("t3_entry0_stable", 64'(ok), 64'd1);
    chk("t3_entry0_old", 64'(entry(0)), 64'h000100);
    run_frame(-1, -1, '0, 12);
    chk("t3_entry0_new", 64'(entry(0)), 64'h000500);

    // Second frame_start mid-fetch is ignored
    run_frame(3, -1, '0, 14);
    chk("t4_miss_at_4", 64'(miss_a[4]), 64'd1);
    chk("t4_miss_count", 64'(count_ones(miss_a, 14)), 64'd1);
    chk("t4_update_at_10", 64'(upd_a[10]), 64'd1);
    chk("t4_update_count", 64'(count_ones(upd_a, 14)), 64'd1);
    ok = 1;
    for (int n = 0; n <= 9; n++) if (idx_a[n] != (n < 8 ? n : 8)) ok = 0;
    chk("t4_rd_index_walk", 64'(ok), 64'd1);
    chk("t4_rd_index_back0", 64'(idx_a[10]), 64'd0);

    // frame_start at the commit edge is missed
    run_frame(9, -1, '0, 13);
    chk("t6_commit_edge_miss", 64'(miss_a[10]), 64'd1);
    chk("t6_commit_edge_update_count", 64'(count_ones(upd_a, 13)), 64'd1);
    // frame_start in the update cycle is accepted back-to-back
    run_frame(10, -1, '0, 24);
    chk("t6_b2b_miss_count", 64'(count_ones(miss_a, 24)), 64'd0);
    chk("t6_b2b_busy_11", 64'(busy_a[11]), 64'd1);
    chk("t6_b2b_update_10", 64'(upd_a[10]), 64'd1);
    chk("t6_b2b_update_21", 64'(upd_a[21]), 64'd1);
    chk("t6_b2b_update_count", 64'(count_ones(upd_a, 24)), 64'd2);

    // Asynchronous reset in the middle of a fetch
    for (int k = 0; k < NP; k++) bank[k] = {1'b1, 15'(k + 3), 8'h40};
    @(negedge clk) frame_start = 1'b1;
    @(negedge clk) frame_start = 1'b0;
    repeat (5) @(negedge clk);
    #1 reset = 1'b1;
    #1;
    chk("t5_reset_tc", 64'(params_tc != '0), 64'd0);
    chk("t5_reset_valid", 64'(params_valid), 64'd0);
    chk("t5_reset_busy", 64'(busy), 64'd0);
    @(negedge clk);
    reset = 1'b0;
    ok = 1;
    for (int n = 0; n < 12; n++) begin
      @(negedge clk);
      if (params_update || busy) ok = 0;
    end
    chk("t5_quiet_after_reset", 64'(ok), 64'd1);
    run_frame(-1, -1, '0, 12);
    for (int k = 0; k < NP; k++)
      chk($sformatf("t5_entry%0d", k), 64'(entry(k)), 64'(ref_tc(bank[k])));
    chk("t5_valid", 64'(params_valid), 64'd1);

    // Randomized banks against the reference conversion
    for (int r = 0; r < 8; r++) begin
      for (int k = 0; k < NP; k++) begin
        bank[k] = 24'($urandom);
        if ($urandom_range(0, 7) == 0) bank[k] = {bank[k][W-1], 23'd0};
      end
      repeat ($urandom_range(0, 3)) @(negedge clk);
      run_frame(-1, -1, '0, 12);
      for (int k = 0; k < NP; k++)
        chk($sformatf("rnd%0d_entry%0d_sm%0h", r, k, bank[k]), 64'(entry(k)), 64'(ref_tc(bank[k])));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
